if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the RV32 core. Keeps the fetch PC and
//  issues one-outstanding requests to instruction memory. Registers returned words into IF/ID.
//  Its 'ins' output drives the immediate generator and decoder. Handles ID stalls and branch/jump
//  redirects, including redirects that arrive while a fetch is still in flight.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset
//  NOP_INS   32'h0000_0013  word loaded into IF/ID on flush/bubble (addi x0,x0,0)
// PORTS
//  clk             in   1   single core clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  imem_req        out  1   fetch request valid
//  imem_addr       out  32  fetch address (always word aligned)
//  imem_gnt        in   1   memory accepts request this cycle (req & gnt = handshake)
//  imem_rvalid     in   1   read data valid; earliest one cycle after grant
//  imem_rdata      in   32  instruction word
//  stall_id        in   1   ID cannot accept; hold IF/ID contents
//  redirect_valid  in   1   branch/jump taken, one-cycle pulse
//  redirect_pc     in   32  redirect target
//  ins             out  32  IF/ID instruction to immediate generator / decoder
//  pc_id           out  32  PC of 'ins'
//  valid_id        out  1   'ins' is a real instruction
//  fetch_misaligned out 1   misaligned redirect flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync deassert): pc_f=RESET_PC, state=S_REQ, imem_req=0, imem_addr=RESET_PC.
//    Also ins=NOP_INS, pc_id=0, valid_id=0, fetch_misaligned=0, hold buffer empty.
//    imem_req first rises the cycle after rst_n deasserts.
//  imem_addr = pc_f in all states. imem_req=1 only in S_REQ (and not in the reset-release cycle).
//  FSM states S_REQ, S_WAIT, S_HOLD, S_DROP; redirect_valid has priority over every other event:
//   S_REQ : redirect -> pc_f=target; go S_DROP if gnt same cycle, else stay S_REQ.
//           gnt -> S_WAIT.
//   S_WAIT: redirect -> pc_f=target; go S_REQ if rvalid same cycle (data discarded), else S_DROP.
//           rvalid & !stall_id -> load IF/ID, pc_f+=4, go S_REQ.
//           rvalid & stall_id -> capture data in hold buffer, go S_HOLD.
//   S_HOLD: redirect -> discard buffer, pc_f=target, go S_REQ.
//           !stall_id -> load IF/ID from buffer, pc_f+=4, go S_REQ.
//   S_DROP: rvalid -> discard data, go S_REQ. pc_f already holds the target.
//  IF/ID load: ins=rdata (or buffer), pc_id=pc_f, valid_id=1.
//  IF/ID update when nothing is loaded:
//   - stall_id=1 holds ins/pc_id/valid_id.
//   - stall_id=0 inserts a bubble: valid_id=0, ins=NOP_INS, pc_id unchanged.
//   - redirect_valid always flushes the same edge, even under stall: valid_id=0, ins=NOP_INS.
//  Latency: grant in cycle N, rvalid in N+k (k>=1) -> ins/valid_id visible at N+k+1.
//    Back-to-back zero-wait memory gives one instruction every 2 cycles.
//  pc_f+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
//  redirect_pc[1:0] is always cleared before loading pc_f.
//  Reset asserted mid-fetch: state returns to S_REQ. Any later rvalid belonging to the old request
//    is ignored only if it arrives while rst_n=0.
// CONFIGURATION
//  FETCH_MISALIGN_CHK_EN defined:
//    - redirect_valid with redirect_pc[1:0]!=0 gives a one-cycle fetch_misaligned=1 pulse on the next edge.
//    - The redirect is still taken with the low bits cleared.
//  FETCH_MISALIGN_CHK_EN undefined: fetch_misaligned is tied 0; the low bits are cleared silently.
// TESTING
//  1 Reset release, RESET_PC=0, gnt=1, rvalid 1 cycle later, words 0x00500093,0x00A00113
//    -> ins/pc_id = (0x00500093,0) then (0x00A00113,4), valid_id=1 on each load.
//  2 stall_id=1 for 3 cycles while rvalid returns 0x12345678
//    -> IF/ID holds old value, FSM in S_HOLD. Release -> ins=0x12345678 next edge, no refetch.
//  3 redirect_valid to 0x100 while in S_WAIT
//    -> S_DROP; the late rvalid word is discarded and never reaches ins.
//    -> next imem_addr=0x100; valid_id=0 and ins=0x00000013 the cycle after the redirect.
//  4 Redirect in same cycle as gnt, and redirect in same cycle as rvalid
//    -> no stale word loaded; exactly one subsequent request to the target.
//  5 pc_f=0xFFFFFFFC fetch completes -> next imem_addr=0x00000000.
//  6 With FETCH_MISALIGN_CHK_EN, redirect_pc=0x102
//    -> fetch_misaligned=1 for exactly one cycle, imem_addr=0x100. Without the macro it stays 0.
//  7 rst_n asserted during S_WAIT
//    -> all outputs return to reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage and IF/ID register: one outstanding imem request, ID stall hold buffer,
// redirect flush/drop. Optional macro FETCH_MISALIGN_CHK_EN flags misaligned redirect targets.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ins,
  output logic [31:0] pc_id,
  output logic        valid_id,
  output logic        fetch_misaligned
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_f, pc_f_nxt;
  logic [31:0] hold_buf, hold_buf_nxt;
  logic        started;
  logic        load;
  logic [31:0] load_dat;
  logic        hs;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  // started keeps the request low during the first cycle after reset release
  assign imem_req     = started && (state == S_REQ);
  assign imem_addr    = pc_f;
  assign hs           = imem_req & imem_gnt;

  always_comb begin
    state_nxt    = state;
    pc_f_nxt     = pc_f;
    hold_buf_nxt = hold_buf;
    load         = 1'b0;
    load_dat     = imem_rdata;
    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_f_nxt  = redirect_tgt;
          state_nxt = hs ? S_DROP : S_REQ;
        end else if (hs) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_f_nxt  = redirect_tgt;
          state_nxt = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid && !stall_id) begin
          load      = 1'b1;
          pc_f_nxt  = pc_f + 32'd4;
          state_nxt = S_REQ;
        end else if (imem_rvalid) begin
          hold_buf_nxt = imem_rdata;
          state_nxt    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_f_nxt  = redirect_tgt;
          state_nxt = S_REQ;
        end else if (!stall_id) begin
          load      = 1'b1;
          load_dat  = hold_buf;
          pc_f_nxt  = pc_f + 32'd4;
          state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        // the in-flight word belongs to the old path; pc_f already points at the target
        if (redirect_valid) pc_f_nxt = redirect_tgt;
        if (imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc_f     <= RESET_PC;
      hold_buf <= 32'h0;
      started  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_f     <= pc_f_nxt;
      hold_buf <= hold_buf_nxt;
      started  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins      <= NOP_INS;
      pc_id    <= 32'h0;
      valid_id <= 1'b0;
    end else if (redirect_valid) begin
      ins      <= NOP_INS;
      valid_id <= 1'b0;
    end else if (load) begin
      ins      <= load_dat;
      pc_id    <= pc_f;
      valid_id <= 1'b1;
    end else if (!stall_id) begin
      ins      <= NOP_INS;
      valid_id <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_misaligned <= 1'b0;
    else        fetch_misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
`else
  logic unused_pc_lo;
  assign unused_pc_lo     = ^redirect_pc[1:0];
  assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed cycle table, hand-written corner sequences, random program-order scoreboard.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall_id = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] ins;
  logic [31:0] pc_id;
  logic        valid_id;
  logic        fetch_misaligned;

  int total = 0;
  int bad = 0;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_id(stall_id), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ins(ins), .pc_id(pc_id), .valid_id(valid_id), .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        vld;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic g, logic rv, logic [31:0] rd, logic st, logic rdr, logic [31:0] rp,
                              logic rq, logic [31:0] ad, logic [31:0] in, logic [31:0] pc, logic vl);
    vec_t v;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.stall = st; v.redir = rdr; v.rpc = rp;
    v.req = rq; v.addr = ad; v.ins = in; v.pc = pc; v.vld = vl;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then land 1 time unit after the next rising edge.
  task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                      input logic st, input logic rdr, input logic [31:0] rp);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    stall_id = st; redirect_valid = rdr; redirect_pc = rp;
    @(posedge clk); #1;
  endtask

  task automatic chk_outs(input string tag, input logic rq, input logic [31:0] ad,
                          input logic [31:0] in, input logic [31:0] pc, input logic vl);
    chk({tag, ".req"},   {31'h0, imem_req}, {31'h0, rq});
    chk({tag, ".addr"},  imem_addr, ad);
    chk({tag, ".ins"},   ins, in);
    chk({tag, ".pc_id"}, pc_id, pc);
    chk({tag, ".valid"}, {31'h0, valid_id}, {31'h0, vl});
  endtask

  initial begin
    // fetch, stall/hold, redirect in S_WAIT, redirect with gnt, redirect with rvalid
    tbl[0]  = mk(1,0,32'h0,        0,0,32'h0,   0,32'h000,NOP,         32'h0,  0);
    tbl[1]  = mk(1,0,32'h0,        0,0,32'h0,   1,32'h000,NOP,         32'h0,  0);
    tbl[2]  = mk(0,1,32'h00500093, 0,0,32'h0,   0,32'h000,NOP,         32'h0,  0);
    tbl[3]  = mk(1,0,32'h0,        0,0,32'h0,   1,32'h004,32'h00500093,32'h0,  1);
    tbl[4]  = mk(0,1,32'h00A00113, 0,0,32'h0,   0,32'h004,NOP,         32'h0,  0);
    tbl[5]  = mk(1,0,32'h0,        1,0,32'h0,   1,32'h008,32'h00A00113,32'h4,  1);
    tbl[6]  = mk(0,1,32'h12345678, 1,0,32'h0,   0,32'h008,32'h00A00113,32'h4,  1);
    tbl[7]  = mk(0,0,32'h0,        1,0,32'h0,   0,32'h008,32'h00A00113,32'h4,  1);
    tbl[8]  = mk(0,0,32'h0,        1,0,32'h0,   0,32'h008,32'h00A00113,32'h4,  1);
    tbl[9]  = mk(0,0,32'h0,        0,0,32'h0,   0,32'h008,32'h00A00113,32'h4,  1);
    tbl[10] = mk(1,0,32'h0,        0,0,32'h0,   1,32'h00C,32'h12345678,32'h8,  1);
    tbl[11] = mk(0,0,32'h0,        0,1,32'h100, 0,32'h00C,NOP,         32'h8,  0);
    tbl[12] = mk(0,1,32'hDEADBEEF, 0,0,32'h0,   0,32'h100,NOP,         32'h8,  0);
    tbl[13] = mk(1,0,32'h0,        0,1,32'h200, 1,32'h100,NOP,         32'h8,  0);
    tbl[14] = mk(0,1,32'hBAD0BAD0, 0,0,32'h0,   0,32'h200,NOP,         32'h8,  0);
    tbl[15] = mk(1,0,32'h0,        0,0,32'h0,   1,32'h200,NOP,         32'h8,  0);
    tbl[16] = mk(0,1,32'hBAD1BAD1, 0,1,32'h300, 0,32'h200,NOP,         32'h8,  0);
    tbl[17] = mk(1,0,32'h0,        0,0,32'h0,   1,32'h300,NOP,         32'h8,  0);
    tbl[18] = mk(0,1,32'h00000517, 0,0,32'h0,   0,32'h300,NOP,         32'h8,  0);
    tbl[19] = mk(0,0,32'h0,        0,0,32'h0,   1,32'h304,32'h00000517,32'h300,1);
    tbl[20] = mk(0,0,32'h0,        0,0,32'h0,   1,32'h304,NOP,         32'h300,0);

    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 0, 32'h0, NOP, 32'h0, 0);
    chk("reset.mis", {31'h0, fetch_misaligned}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      chk_outs($sformatf("tbl%0d", i), tbl[i].req, tbl[i].addr, tbl[i].ins, tbl[i].pc, tbl[i].vld);
      step(tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].stall, tbl[i].redir, tbl[i].rpc);
    end

    // PC wrap at the top of the address space
    step(0,0,32'h0,0,1,32'hFFFF_FFFC);
    chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    step(1,0,32'h0,0,0,32'h0);
    step(0,1,32'h0000_0093,0,0,32'h0);
    chk_outs("wrap", 1, 32'h0, 32'h0000_0093, 32'hFFFF_FFFC, 1);

    // misaligned redirect target
    step(0,0,32'h0,0,1,32'h0000_0102);
    chk("mis.addr", imem_addr, 32'h100);
    chk("mis.pulse", {31'h0, fetch_misaligned}, {31'h0, MIS_EN});
    chk("mis.valid", {31'h0, valid_id}, 32'h0);
    step(0,0,32'h0,0,0,32'h0);
    chk("mis.clear", {31'h0, fetch_misaligned}, 32'h0);

    // reset asserted while a fetch is in flight
    step(1,0,32'h0,0,0,32'h0);
    chk("rst.wait_req", {31'h0, imem_req}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk_outs("rst.async", 0, 32'h0, NOP, 32'h0, 0);
    step(0,1,32'hBADB_AD00,0,0,32'h0);
    step(0,0,32'h0,0,0,32'h0);
    rst_n = 1'b1;
    chk("rst.release_req", {31'h0, imem_req}, 32'h0);
    step(1,0,32'h0,0,0,32'h0);
    chk("rst.req", {31'h0, imem_req}, 32'h1);
    chk("rst.addr", imem_addr, 32'h0);
    step(1,0,32'h0,0,0,32'h0);
    step(0,1,32'hCAFE_0013,0,0,32'h0);
    chk_outs("rst.refetch", 1, 32'h4, 32'hCAFE_0013, 32'h0, 1);

    // random phase against a program-order scoreboard
    begin
      logic [31:0] exp_pc, out_addr, prev_ins, prev_pc, rpc, rd;
      logic        outstanding, prev_hold, exp_mis, st, rdr, g, rv;
      int          lat, consumed;
      rst_n = 1'b0;
      step(0,0,32'h0,0,0,32'h0);
      rst_n = 1'b1;
      exp_pc = 32'h0; outstanding = 0; lat = 0; consumed = 0;
      prev_hold = 0; exp_mis = 0; prev_ins = NOP; prev_pc = 0; out_addr = 0;
      for (int c = 0; c < 4000; c++) begin
        if (prev_hold) begin
          chk("rnd.hold_ins", ins, prev_ins);
          chk("rnd.hold_pc", pc_id, prev_pc);
          chk("rnd.hold_vld", {31'h0, valid_id}, 32'h1);
        end
        chk("rnd.mis", {31'h0, fetch_misaligned}, {31'h0, exp_mis});
        if (!valid_id) chk("rnd.bubble_nop", ins, NOP);
        st  = ($urandom % 10) < 3;
        rdr = ($urandom % 100) < 7;
        rpc = $urandom;
        if (rdr) begin
          exp_pc = rpc & 32'hFFFF_FFFC;
        end else if (valid_id && !st) begin
          chk("rnd.pc_order", pc_id, exp_pc);
          chk("rnd.ins_word", ins, mem_word(pc_id));
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
        prev_hold = valid_id && st && !rdr;
        prev_ins  = ins;
        prev_pc   = pc_id;
        exp_mis   = MIS_EN && rdr && (rpc[1:0] != 2'b00);
        rv = 0; rd = $urandom;
        if (outstanding) begin
          if (lat == 0) begin
            rv = 1; rd = mem_word(out_addr); outstanding = 0;
          end else begin
            lat--;
          end
        end
        g = ($urandom % 10) < 7;
        if (imem_req) chk("rnd.align", {30'h0, imem_addr[1:0]}, 32'h0);
        if (imem_req && g) begin
          chk("rnd.one_outstanding", {31'h0, outstanding}, 32'h0);
          outstanding = 1;
          out_addr = imem_addr;
          lat = $urandom_range(0, 2);
        end
        step(g, rv, rd, st, rdr, rpc);
      end
      total++;
      if (consumed < 50) begin
        bad++;
        $display("FAIL rnd.progress: got %0d instructions, expected at least 50", consumed);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
